// File: rtl/ercm8_0.sv
// rtl/ercm8_0.sv - error-configurable 8x8 unsigned approximate multiplier, registered 16-bit product
//
// Purpose:
//    Forms the 8x8 partial-product array and sums it column by column.
//    Each of the seven low-order columns (0..6) is either summed exactly
//    or collapsed to the OR of its bits, as selected by mask. Columns
//    7..14 are always summed exactly. The weighted column values are added
//    and the result is registered.
//
// Ports:
//    clk       rising-edge clock
//    rst_n     asynchronous active-low reset; clears dat_o immediately
//    dat_in_a  unsigned multiplicand a[7:0]
//    dat_in_b  unsigned multiplier b[7:0]
//    mask      per-column control for columns 0..6 (1 = exact, 0 = OR approximation)
//    dat_o     registered product, one cycle after the operands are sampled

module ercm8_0 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  dat_in_a,
   input  logic [7:0]  dat_in_b,
   input  logic [6:0]  mask,
   output logic [15:0] dat_o
);

   // Population count of one partial-product column (column height <= 8).
   function automatic logic [3:0] popcount8(input logic [7:0] v);
      return {3'b0, v[0]} + {3'b0, v[1]} + {3'b0, v[2]} + {3'b0, v[3]}
           + {3'b0, v[4]} + {3'b0, v[5]} + {3'b0, v[6]} + {3'b0, v[7]};
   endfunction

   logic [3:0]  col_val [15];
   logic [15:0] psum    [16];
   logic [15:0] prod_d;
   logic [15:0] prod_q;

   assign psum[0] = 16'h0000;

   for (genvar k = 0; k < 15; k++) begin : g_col
      // Bits of column k; row i holds a[i] & b[k-i], padded with zeros
      // where k-i falls outside the operand.
      logic [7:0] bits;

      for (genvar i = 0; i < 8; i++) begin : g_row
         if ((k - i >= 0) && (k - i <= 7)) begin : g_pp
            assign bits[i] = dat_in_a[i] & dat_in_b[k-i];
         end else begin : g_pad
            assign bits[i] = 1'b0;
         end
      end

      if (k <= 6) begin : g_low
         // An approximated column contributes a single bit at its own
         // weight, so it never carries into column k+1.
         assign col_val[k] = mask[k] ? popcount8(bits) : {3'b0, |bits};
      end else begin : g_high
         assign col_val[k] = popcount8(bits);
      end

      // Weighted accumulation. Written as a chain for clarity; synthesis
      // flattens it into a compressor tree feeding one carry-propagate
      // adder. The total never exceeds 65025, so 16 bits cannot overflow.
      assign psum[k+1] = psum[k] + ({12'b0, col_val[k]} << k);
   end

   assign prod_d = psum[15];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= 16'h0000;
      end else begin
         prod_q <= prod_d;
      end
   end

   assign dat_o = prod_q;

endmodule

// File: tb/tb_ercm8_0.sv
// tb/tb_ercm8_0.sv - self-checking bench for ercm8_0

module tb_ercm8_0;

   logic        clk;
   logic        rst_n;
   logic [7:0]  dat_in_a;
   logic [7:0]  dat_in_b;
   logic [6:0]  mask;
   logic [15:0] dat_o;

   int n_checks;
   int n_errs;

   ercm8_0 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .dat_in_a (dat_in_a),
      .dat_in_b (dat_in_b),
      .mask     (mask),
      .dat_o    (dat_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Column-formula golden model.
   function automatic int golden(input int a, input int b, input int m);
      int p;
      int s;
      p = 0;
      for (int k = 0; k < 15; k++) begin
         s = 0;
         for (int i = 0; i < 8; i++) begin
            if ((k - i >= 0) && (k - i <= 7)) begin
               s += ((a >> i) & 1) & ((b >> (k - i)) & 1);
            end
         end
         if ((k <= 6) && (((m >> k) & 1) == 0)) begin
            s = (s != 0) ? 1 : 0;
         end
         p += s << k;
      end
      return p;
   endfunction

   task automatic apply(input int a, input int b, input int m);
      dat_in_a = 8'(a);
      dat_in_b = 8'(b);
      mask     = 7'(m);
      @(posedge clk);
      #1;
   endtask

   task automatic directed(input string tag, input int a, input int b, input int m, input int exp);
      apply(a, b, m);
      check_eq(tag, int'(dat_o), exp);
   endtask

   initial begin
      int a;
      int b;
      int m;
      int exact;
      int err;
      int err_cnt;
      int err_max;
      longint err_sum;

      n_checks = 0;
      n_errs   = 0;
      rst_n    = 1'b0;
      dat_in_a = 8'd255;
      dat_in_b = 8'd255;
      mask     = 7'h7F;

      // Reset state, including across a clock edge while held.
      #1;
      check_eq("reset_init", int'(dat_o), 0);
      @(posedge clk);
      #1;
      check_eq("reset_held_edge", int'(dat_o), 0);
      #3;
      rst_n = 1'b1;

      // Directed vectors.
      directed("exact_255x255",    255, 255, 7'h7F, 65025);
      directed("approx_255x255",   255, 255, 7'h00, 64383);
      directed("approx_3x3",         3,   3, 7'h00,     7);
      directed("col1_exact_3x3",     3,   3, 7'h02,     9);
      directed("h1_1x200",           1, 200, 7'h00,   200);
      directed("h1_128x255",       128, 255, 7'h00, 32640);
      directed("zero_a_b255",        0, 255, 7'h00,     0);
      directed("zero_a_b77",         0,  77, 7'h55,     0);
      directed("exact_15x15",       15,  15, 7'h7F,   225);
      // 15x15 with mask 0: columns 0..3 -> 1 each (15), columns 4..6 (heights 3,2,1) -> 1 each (112).
      directed("approx_15x15",      15,  15, 7'h00,   127);

      // Back-to-back operands: each edge carries only its own inputs.
      directed("b2b_first",         12,  10, 7'h7F,   120);
      directed("b2b_second",       200,   2, 7'h7F,   400);

      // Asynchronous reset between edges, then recovery.
      directed("pre_reset_load",   255, 255, 7'h7F, 65025);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_reset_now", int'(dat_o), 0);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("post_reset_first", int'(dat_o), 65025);

      // Exhaustive exact mode.
      for (int ia = 0; ia < 256; ia++) begin
         for (int ib = 0; ib < 256; ib++) begin
            apply(ia, ib, 7'h7F);
            check_eq($sformatf("exh_exact_%0dx%0d", ia, ib), int'(dat_o), ia * ib);
         end
      end

      // Random regression against the column model.
      for (int n = 0; n < 10000; n++) begin
         a = int'($urandom_range(0, 255));
         b = int'($urandom_range(0, 255));
         m = int'($urandom_range(0, 127));
         apply(a, b, m);
         check_eq($sformatf("rand_%0dx%0d_m%0h", a, b, m), int'(dat_o), golden(a, b, m));
      end

      // Full approximation: never above the exact product; error statistics.
      err_cnt = 0;
      err_max = 0;
      err_sum = 0;
      for (int n = 0; n < 2000; n++) begin
         a = int'($urandom_range(0, 255));
         b = int'($urandom_range(0, 255));
         apply(a, b, 0);
         exact = a * b;
         check_eq($sformatf("m0_model_%0dx%0d", a, b), int'(dat_o), golden(a, b, 0));
         check_eq($sformatf("m0_bound_%0dx%0d", a, b), (int'(dat_o) <= exact) ? 1 : 0, 1);
         err = exact - int'(dat_o);
         if (err != 0) err_cnt++;
         if (err > err_max) err_max = err;
         err_sum += longint'(err);
      end
      $display("mask=0 stats: error rate %0d/2000, mean error distance %f, max error %0d",
               err_cnt, real'(err_sum) / 2000.0, err_max);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
